gfx_reg_loader: RTL and testbench
=================================

# gfx_reg_loader

Double-buffered register loader and frame-commit controller for the graphics engine. It accepts CPU writes over the memory-mapped bus into shadow registers. It copies the whole shadow set into the active registers in one cycle, at a frame boundary reported by the pixel-scan controller. The active registers drive the paddle, ball, frame/score and control sprite units, so those units never see a frame rendered with a half-updated object set.

## Interface
Parameters:
- CS_CODE, 4'h1, chipselect value that selects this block for a write
- FRAME_TIMEOUT, 16'd0, frames a pending update may wait while frozen before a forced commit; 0 disables the timeout

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- chipselect  in  4  bus select; a write is valid when it equals CS_CODE
- databus  in  16  write data
- data_address  in  4  register index
- frame_end  in  1  one-cycle pulse from the scan controller after the last pixel of a frame
- paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y  out  16 each  active paddle coordinates
- ball_x, ball_y, ball_z  out  16 each  active ball coordinates
- player_1_score, player_2_score  out  16 each  active scores
- game_state  out  16  active game state
- pending  out  1  shadow set differs from the active set (written since the last commit)
- commit_done  out  1  one-cycle pulse on the edge where active registers update

## Operation
- Address map: 0 p1_x, 1 p1_y, 2 p2_x, 3 p2_y, 4 ball_x, 5 ball_y, 6 ball_z, 7 p1_score, 8 p2_score, 9 game_state, 4'hF CTRL. Addresses 10–14: write ignored, no state change.
- CTRL write:
  - bit0 = force-commit request, self-clearing.
  - bit1 = freeze, sticky; cleared by writing 0.
  - Other bits ignored.
- FSM states: IDLE, PENDING, COMMIT.
  - IDLE → PENDING on any valid write to shadow addresses 0–9.
  - PENDING → COMMIT when (frame_end && !freeze), or on a force-commit request, or when the timeout expires.
  - COMMIT lasts one cycle. All ten active registers load from shadow and commit_done=1.
  - COMMIT → PENDING if a shadow write occurs during the COMMIT cycle; otherwise COMMIT → IDLE.
- Force-commit while IDLE: no effect, no commit_done.
- Timeout counter:
  - Counts frame_end pulses while in PENDING with freeze=1.
  - Saturates at FRAME_TIMEOUT; reaching it triggers COMMIT.
  - Clears on COMMIT and whenever freeze=0.
- pending = (state != IDLE).

## Timing
- Reset (rst low, asynchronous):
  - All shadow and active registers are 0, except the score registers per Configuration.
  - freeze=0, state IDLE, pending=0, commit_done=0, timeout counter 0.
- Shadow write: the bus is sampled at edge N; the shadow register holds the new value after edge N.
- Commit: trigger sampled at edge N puts the FSM in COMMIT for cycle N+1. Active outputs change at edge N+2, coincident with the commit_done pulse.
- Latency frame_end → new coordinates: 2 cycles.
- Write in the same cycle as the COMMIT cycle:
  - The commit copies pre-write shadow contents.
  - The new value stays in shadow and the FSM returns to PENDING.
- frame_end while IDLE: ignored.
- frame_end coinciding with force-commit: one commit only.
- Reset asserted mid-COMMIT: actives return to reset values; the commit is lost.

## Configuration
- GFX_SCORE_REGS_EN defined:
  - Addresses 7/8 are writable, double-buffered registers.
  - Reset value is 0.
- GFX_SCORE_REGS_EN undefined:
  - No score flops are built.
  - player_1_score = 16'd1 and player_2_score = 16'd2, constant.
  - Writes to addresses 7/8 are ignored and do not set pending.

## Structure
- Shared package gfx_pkg holds:
  - the address constants (ADDR_P1_X … ADDR_CTRL)
  - the CTRL bit positions
  - the FSM state enum
  - the 16-bit coordinate typedef
  - the register count (10)
- One sub-module, gfx_frame_timeout: the saturating frame counter with clear/enable/expired.

## Test plan
- Reset, then write p1_x=16'd120 at address 0 with CS_CODE → shadow updated, pending=1, paddle_1_x stays 0 until frame_end; it reads 120 two cycles after frame_end, with commit_done pulsed once.
- Set freeze (CTRL=2), write ball_x=300, pulse frame_end ×3 with FRAME_TIMEOUT=0 → ball_x stays 0, pending=1. Write CTRL=1 → ball_x=300 two cycles later.
- FRAME_TIMEOUT=2, freeze set, write ball_y=50, 2 frame_end pulses → commit after the second pulse, ball_y=50.
- Write ball_z=7 in the COMMIT cycle of a prior ball_z=5 update → ball_z=5 after that commit, pending=1; next frame_end gives ball_z=7.
- Write chipselect=4'h2 or address 12 → no register change, pending=0. Force-commit while IDLE → no commit_done.
- With GFX_SCORE_REGS_EN undefined: write address 7=9 → player_1_score remains 1 and pending remains 0. With it defined: scores update to 9 after the next frame_end.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared definitions for gfx_reg_loader: register address map, CTRL bit
// positions, FSM state encoding and the coordinate word type.
package gfx_pkg;

  typedef logic [15:0] coord_t;

  localparam int NUM_REGS = 10;

  localparam logic [3:0] ADDR_P1_X       = 4'd0;
  localparam logic [3:0] ADDR_P1_Y       = 4'd1;
  localparam logic [3:0] ADDR_P2_X       = 4'd2;
  localparam logic [3:0] ADDR_P2_Y       = 4'd3;
  localparam logic [3:0] ADDR_BALL_X     = 4'd4;
  localparam logic [3:0] ADDR_BALL_Y     = 4'd5;
  localparam logic [3:0] ADDR_BALL_Z     = 4'd6;
  localparam logic [3:0] ADDR_P1_SCORE   = 4'd7;
  localparam logic [3:0] ADDR_P2_SCORE   = 4'd8;
  localparam logic [3:0] ADDR_GAME_STATE = 4'd9;
  localparam logic [3:0] ADDR_CTRL       = 4'hF;

  localparam int CTRL_FORCE_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/gfx_frame_timeout.sv
// Saturating frame counter: counts ticks while enabled and flags expiry in the
// same cycle the LIMIT-th tick arrives. LIMIT = 0 never expires.
module gfx_frame_timeout #(
  parameter logic [15:0] LIMIT = 16'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_tick,
  output logic o_expired
);

  logic [15:0] r_count;
  logic        w_at_limit;
  logic        w_hits_limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 16'd0;
    end else if (i_clear) begin
      r_count <= 16'd0;
    end else if (i_enable && i_tick && (r_count != LIMIT)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign w_at_limit   = (r_count == LIMIT);
  assign w_hits_limit = i_tick && (r_count == (LIMIT - 16'd1));

  assign o_expired = (LIMIT != 16'd0) && i_enable && !i_clear &&
                     (w_at_limit || w_hits_limit);

endmodule

// File: rtl/gfx_reg_loader.sv
// Double-buffered register loader: CPU writes land in shadow registers and are
// copied to the active set at a frame boundary. Optional: GFX_SCORE_REGS_EN.
module gfx_reg_loader
  import gfx_pkg::*;
#(
  parameter logic [3:0]  CS_CODE       = 4'h1,
  parameter logic [15:0] FRAME_TIMEOUT = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  chipselect,
  input  logic [15:0] databus,
  input  logic [3:0]  data_address,
  input  logic        frame_end,
  output logic [15:0] paddle_1_x,
  output logic [15:0] paddle_1_y,
  output logic [15:0] paddle_2_x,
  output logic [15:0] paddle_2_y,
  output logic [15:0] ball_x,
  output logic [15:0] ball_y,
  output logic [15:0] ball_z,
  output logic [15:0] player_1_score,
  output logic [15:0] player_2_score,
  output logic [15:0] game_state,
  output logic        pending,
  output logic        commit_done
);

  // Score slots only exist as real registers when the score feature is built.
  function automatic logic reg_present(input int idx);
`ifdef GFX_SCORE_REGS_EN
    return (idx < NUM_REGS);
`else
    return (idx < NUM_REGS) &&
           (idx != int'(ADDR_P1_SCORE)) && (idx != int'(ADDR_P2_SCORE));
`endif
  endfunction

  coord_t r_shadow [NUM_REGS];
  coord_t r_active [NUM_REGS];
  state_t r_state;
  logic   r_freeze;
  logic   r_commit_req;
  logic   r_commit_done;

  logic w_sel;
  logic w_shadow_wr;
  logic w_ctrl_wr;
  logic w_force;
  logic w_expired;
  logic w_trigger;
  logic w_to_enable;
  logic w_to_clear;

  assign w_sel       = (chipselect == CS_CODE);
  assign w_shadow_wr = w_sel && (data_address <= ADDR_GAME_STATE) &&
                       reg_present(int'(data_address));
  assign w_ctrl_wr   = w_sel && (data_address == ADDR_CTRL);
  assign w_force     = w_ctrl_wr && databus[CTRL_FORCE_BIT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_present(i)) r_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_present(i) && w_shadow_wr && (data_address == 4'(i))) begin
          r_shadow[i] <= databus;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_freeze <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_freeze <= databus[CTRL_FREEZE_BIT];
    end
  end

  assign w_to_enable = (r_state == PENDING) && r_freeze;
  assign w_to_clear  = (r_state == COMMIT) || !r_freeze;

  gfx_frame_timeout #(
    .LIMIT(FRAME_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_to_clear),
    .i_enable (w_to_enable),
    .i_tick   (frame_end),
    .o_expired(w_expired)
  );

  assign w_trigger = (frame_end && !r_freeze) || w_force || w_expired;

  // The trigger is latched for one cycle so COMMIT follows the sampling edge
  // by one cycle; back-to-back triggers collapse into a single commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_commit_req  <= 1'b0;
      r_commit_done <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_present(i)) r_active[i] <= '0;
      end
    end else begin
      r_commit_done <= 1'b0;
      r_commit_req  <= (r_state == PENDING) && !r_commit_req && w_trigger;
      case (r_state)
        IDLE: begin
          if (w_shadow_wr) r_state <= PENDING;
        end
        PENDING: begin
          if (r_commit_req) r_state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_present(i)) r_active[i] <= r_shadow[i];
          end
          r_commit_done <= 1'b1;
          r_state       <= w_shadow_wr ? PENDING : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign paddle_1_x = r_active[ADDR_P1_X];
  assign paddle_1_y = r_active[ADDR_P1_Y];
  assign paddle_2_x = r_active[ADDR_P2_X];
  assign paddle_2_y = r_active[ADDR_P2_Y];
  assign ball_x     = r_active[ADDR_BALL_X];
  assign ball_y     = r_active[ADDR_BALL_Y];
  assign ball_z     = r_active[ADDR_BALL_Z];
  assign game_state = r_active[ADDR_GAME_STATE];

`ifdef GFX_SCORE_REGS_EN
  assign player_1_score = r_active[ADDR_P1_SCORE];
  assign player_2_score = r_active[ADDR_P2_SCORE];
`else
  assign player_1_score = 16'd1;
  assign player_2_score = 16'd2;
`endif

  assign pending     = (r_state != IDLE);
  assign commit_done = r_commit_done;

endmodule

// File: tb/tb_gfx_reg_loader.sv
// Scoreboard bench for gfx_reg_loader: stimulus pushes the expected active set
// before each commit, monitors pop and compare on every commit_done pulse.
module tb_gfx_reg_loader;
  import gfx_pkg::*;

  localparam logic [3:0] CS = 4'h1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  chipselect;
  logic [3:0]  data_address;
  logic [15:0] databus;
  logic        frame_end;
  logic [15:0] paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y;
  logic [15:0] ball_x, ball_y, ball_z;
  logic [15:0] player_1_score, player_2_score, game_state;
  logic        pending, commit_done;

  logic [3:0]  t_cs;
  logic [3:0]  t_addr;
  logic [15:0] t_data;
  logic        t_fe;
  logic [15:0] t_out [10];
  logic        t_pending, t_commit_done;

  int checkCount = 0;
  int passCount  = 0;

  logic [159:0] expQ [$];
  logic [15:0]  expQ2 [$];
  logic [15:0]  expAct [10];

  gfx_reg_loader #(.CS_CODE(4'h1), .FRAME_TIMEOUT(16'd0)) dut (
    .clk(clk), .rst(rst), .chipselect(chipselect), .databus(databus),
    .data_address(data_address), .frame_end(frame_end),
    .paddle_1_x(paddle_1_x), .paddle_1_y(paddle_1_y),
    .paddle_2_x(paddle_2_x), .paddle_2_y(paddle_2_y),
    .ball_x(ball_x), .ball_y(ball_y), .ball_z(ball_z),
    .player_1_score(player_1_score), .player_2_score(player_2_score),
    .game_state(game_state), .pending(pending), .commit_done(commit_done)
  );

  gfx_reg_loader #(.CS_CODE(4'h1), .FRAME_TIMEOUT(16'd2)) dutTimeout (
    .clk(clk), .rst(rst), .chipselect(t_cs), .databus(t_data),
    .data_address(t_addr), .frame_end(t_fe),
    .paddle_1_x(t_out[0]), .paddle_1_y(t_out[1]),
    .paddle_2_x(t_out[2]), .paddle_2_y(t_out[3]),
    .ball_x(t_out[4]), .ball_y(t_out[5]), .ball_z(t_out[6]),
    .player_1_score(t_out[7]), .player_2_score(t_out[8]),
    .game_state(t_out[9]), .pending(t_pending), .commit_done(t_commit_done)
  );

  task automatic checkOutput(input string name, input logic [159:0] actual,
                             input logic [159:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic logic [159:0] packExp();
    logic [159:0] r;
    for (int i = 0; i < 10; i++) r[i*16 +: 16] = expAct[i];
    return r;
  endfunction

  function automatic logic [159:0] packAct();
    return {game_state, player_2_score, player_1_score, ball_z, ball_y, ball_x,
            paddle_2_y, paddle_2_x, paddle_1_y, paddle_1_x};
  endfunction

  task automatic resetExpected();
    for (int i = 0; i < 10; i++) expAct[i] = 16'd0;
`ifndef GFX_SCORE_REGS_EN
    expAct[7] = 16'd1;
    expAct[8] = 16'd2;
`endif
  endtask

  // One bus cycle on the main instance, then the bus returns to idle.
  task automatic applyStimulus(input logic [3:0] cs, input logic [3:0] addr,
                               input logic [15:0] data, input logic fe);
    @(negedge clk);
    chipselect = cs; data_address = addr; databus = data; frame_end = fe;
    @(negedge clk);
    chipselect = 4'h0; data_address = 4'h0; databus = 16'h0; frame_end = 1'b0;
  endtask

  task automatic applyTimeoutStimulus(input logic [3:0] cs, input logic [3:0] addr,
                                      input logic [15:0] data, input logic fe);
    @(negedge clk);
    t_cs = cs; t_addr = addr; t_data = data; t_fe = fe;
    @(negedge clk);
    t_cs = 4'h0; t_addr = 4'h0; t_data = 16'h0; t_fe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && commit_done === 1'b1) begin
      if (expQ.size() == 0) checkOutput("unexpected commit_done", commit_done, 1'b0);
      else checkOutput("committed active set", packAct(), expQ.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && t_commit_done === 1'b1) begin
      if (expQ2.size() == 0) checkOutput("timeout unexpected commit_done", t_commit_done, 1'b0);
      else checkOutput("timeout committed ball_y", t_out[5], expQ2.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    chipselect = 4'h0; data_address = 4'h0; databus = 16'h0; frame_end = 1'b0;
    t_cs = 4'h0; t_addr = 4'h0; t_data = 16'h0; t_fe = 1'b0;
    resetExpected();
    idle(3);
    rst = 1'b1;
    idle(1);

    checkOutput("reset pending", pending, 1'b0);
    checkOutput("reset commit_done", commit_done, 1'b0);
    checkOutput("reset active set", packAct(), packExp());
    checkOutput("timeout reset pending", t_pending, 1'b0);

    // Plain write followed by a frame boundary.
    applyStimulus(CS, ADDR_P1_X, 16'd120, 1'b0);
    checkOutput("pending after write", pending, 1'b1);
    checkOutput("p1_x before frame", paddle_1_x, 16'd0);
    idle(2);
    checkOutput("p1_x still old", paddle_1_x, 16'd0);
    expAct[0] = 16'd120;
    expQ.push_back(packExp());
    applyStimulus(4'h0, 4'h0, 16'h0, 1'b1);
    idle(1);
    checkOutput("p1_x one cycle after frame", paddle_1_x, 16'd0);
    checkOutput("commit_done one cycle after frame", commit_done, 1'b0);
    idle(1);
    checkOutput("p1_x two cycles after frame", paddle_1_x, 16'd120);
    checkOutput("commit_done two cycles after frame", commit_done, 1'b1);
    idle(1);
    checkOutput("commit_done single pulse", commit_done, 1'b0);
    checkOutput("pending cleared", pending, 1'b0);

    // Frozen update survives frames, then force-commit releases it.
    applyStimulus(CS, ADDR_CTRL, 16'h0002, 1'b0);
    applyStimulus(CS, ADDR_BALL_X, 16'd300, 1'b0);
    repeat (3) begin
      applyStimulus(4'h0, 4'h0, 16'h0, 1'b1);
      idle(2);
    end
    checkOutput("ball_x while frozen", ball_x, 16'd0);
    checkOutput("pending while frozen", pending, 1'b1);
    expAct[4] = 16'd300;
    expQ.push_back(packExp());
    applyStimulus(CS, ADDR_CTRL, 16'h0001, 1'b0);
    idle(1);
    checkOutput("ball_x one cycle after force", ball_x, 16'd0);
    idle(1);
    checkOutput("ball_x two cycles after force", ball_x, 16'd300);
    idle(1);
    checkOutput("pending after force commit", pending, 1'b0);

    // Write landing in the COMMIT cycle stays in shadow for the next frame.
    applyStimulus(CS, ADDR_BALL_Z, 16'd5, 1'b0);
    expAct[6] = 16'd5;
    expQ.push_back(packExp());
    applyStimulus(4'h0, 4'h0, 16'h0, 1'b1);
    applyStimulus(CS, ADDR_BALL_Z, 16'd7, 1'b0);
    checkOutput("ball_z after first commit", ball_z, 16'd5);
    checkOutput("commit_done with overlapping write", commit_done, 1'b1);
    checkOutput("pending after overlapping write", pending, 1'b1);
    idle(2);
    checkOutput("ball_z held before next frame", ball_z, 16'd5);
    expAct[6] = 16'd7;
    expQ.push_back(packExp());
    applyStimulus(4'h0, 4'h0, 16'h0, 1'b1);
    idle(2);
    checkOutput("ball_z after second commit", ball_z, 16'd7);

    // frame_end together with force-commit yields one commit.
    applyStimulus(CS, ADDR_P2_X, 16'd33, 1'b0);
    expAct[2] = 16'd33;
    expQ.push_back(packExp());
    applyStimulus(CS, ADDR_CTRL, 16'h0001, 1'b1);
    idle(2);
    checkOutput("p2_x after coincident triggers", paddle_2_x, 16'd33);
    idle(4);
    checkOutput("pending after coincident triggers", pending, 1'b0);

    // Ignored accesses: foreign chipselect, reserved address, idle force.
    applyStimulus(4'h2, ADDR_P1_X, 16'd999, 1'b0);
    checkOutput("pending after foreign chipselect", pending, 1'b0);
    applyStimulus(CS, 4'd12, 16'd55, 1'b0);
    checkOutput("pending after reserved address", pending, 1'b0);
    applyStimulus(CS, ADDR_CTRL, 16'h0001, 1'b0);
    repeat (3) begin
      checkOutput("commit_done after idle force", commit_done, 1'b0);
      idle(1);
    end
    checkOutput("actives after ignored accesses", packAct(), packExp());
    applyStimulus(CS, ADDR_P2_Y, 16'd44, 1'b0);
    expAct[3] = 16'd44;
    expQ.push_back(packExp());
    applyStimulus(4'h0, 4'h0, 16'h0, 1'b1);
    idle(2);
    checkOutput("p2_y after frame", paddle_2_y, 16'd44);

    // Timeout instance: two frozen frames force the commit.
    applyTimeoutStimulus(CS, ADDR_CTRL, 16'h0002, 1'b0);
    applyTimeoutStimulus(CS, ADDR_BALL_Y, 16'd50, 1'b0);
    applyTimeoutStimulus(4'h0, 4'h0, 16'h0, 1'b1);
    idle(4);
    checkOutput("timeout ball_y after one frame", t_out[5], 16'd0);
    checkOutput("timeout pending after one frame", t_pending, 1'b1);
    expQ2.push_back(16'd50);
    applyTimeoutStimulus(4'h0, 4'h0, 16'h0, 1'b1);
    idle(1);
    checkOutput("timeout ball_y one cycle after expiry", t_out[5], 16'd0);
    idle(1);
    checkOutput("timeout ball_y two cycles after expiry", t_out[5], 16'd50);
    idle(1);
    checkOutput("timeout pending after commit", t_pending, 1'b0);

    // Reset asserted during COMMIT discards the commit.
    applyStimulus(CS, ADDR_P1_Y, 16'd77, 1'b0);
    applyStimulus(4'h0, 4'h0, 16'h0, 1'b1);
    idle(1);
    rst = 1'b0;
    #1;
    resetExpected();
    checkOutput("actives after mid-commit reset", packAct(), packExp());
    checkOutput("pending after mid-commit reset", pending, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    checkOutput("p1_y after reset recovery", paddle_1_y, 16'd0);
    checkOutput("pending after reset recovery", pending, 1'b0);

    // Score registers depend on the build option.
    applyStimulus(CS, ADDR_P1_SCORE, 16'd9, 1'b0);
`ifdef GFX_SCORE_REGS_EN
    checkOutput("pending after score write", pending, 1'b1);
    expAct[7] = 16'd9;
    expQ.push_back(packExp());
    applyStimulus(4'h0, 4'h0, 16'h0, 1'b1);
    idle(2);
    checkOutput("player_1_score after frame", player_1_score, 16'd9);
`else
    checkOutput("pending after score write", pending, 1'b0);
    checkOutput("player_1_score constant", player_1_score, 16'd1);
    applyStimulus(4'h0, 4'h0, 16'h0, 1'b1);
    idle(2);
    checkOutput("commit_done after score frame", commit_done, 1'b0);
    checkOutput("player_2_score constant", player_2_score, 16'd2);
`endif

    idle(4);
    checkOutput("main scoreboard drained", expQ.size(), 0);
    checkOutput("timeout scoreboard drained", expQ2.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
